control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
Multi-cycle instruction-sequencing controller that sits directly upstream of the processor datapath. It decodes the datapath's `opcode` and `zflag` outputs and drives every datapath load/mux/ALU strobe, plus the memory write enable. It also handshakes with the datapath's ×2 multiplier through `mullACC`/`mullDone`.

Parameters:
MUL_TIMEOUT, 16, maximum S_MUL cycles waited for mullDone before error halt.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
opcode  in  8  IR[7:0] from datapath
zflag  in  1  accumulator-zero flag from datapath
mullDone  in  1  multiplier completion, level, from datapath
muxPC  out  1  1: PC<=IR branch target; 0: PC<=PC+1
muxMAR  out  1  1: MAR<=PC; 0: MAR<=IR[15:8]
muxACC  out  1  1: ACC<=MDR; 0: ACC<=ALU result
loadPC  out  1  PC load strobe
loadMAR  out  1  MAR load strobe
loadMDR  out  1  MDR<=MemQ strobe
loadIR  out  1  IR<=MDR strobe
loadACC  out  1  ACC load strobe
opALU  out  1  ALU select: 0 ADD, 1 SUB
mullACC  out  1  multiplier run/ACC<=ACC*2 request
MemW  out  1  memory write enable (MemD=ACC at MemAddr)
halted  out  1  high while in S_HALT
err  out  1  sticky multiplier-timeout flag
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Async reset (rst=1, no clock needed): state=S_FETCH0; all outputs, mul counter and instr_count = 0. Reset mid-instruction abandons it; no partial strobes survive.
- All outputs are registered Moore outputs, decoded from next-state and loaded with the state register. They are glitch-free and stable for a full cycle. Any output not listed for a state is 0.
- Opcode map (IR[7:0]):
  - 00 NOP
  - 01 LOAD
  - 02 STORE
  - 03 ADD
  - 04 SUB
  - 05 JUMP
  - 06 JMPZ
  - 07 MUL2
  - 08 HALT
  - All other values execute as NOP.
- S_FETCH0: loadMAR, muxMAR=1 -> S_FETCH1.
- S_FETCH1: loadMDR; loadPC, muxPC=0 -> S_FETCH2.
- S_FETCH2: loadIR -> S_DECODE.
- S_DECODE: no strobes. Branch by opcode:
  - LOAD/ADD/SUB -> S_RD0
  - STORE -> S_ST0
  - JUMP -> S_JMP
  - JMPZ -> S_JMP if zflag=1, else S_FETCH0 (zflag sampled in S_DECODE only)
  - MUL2 -> S_MUL
  - HALT -> S_HALT
  - NOP/undefined -> S_FETCH0
- S_RD0: loadMAR, muxMAR=0 -> S_RD1.
- S_RD1: loadMDR -> S_RD2.
- S_RD2: loadACC.
  - LOAD: muxACC=1.
  - ADD: muxACC=0, opALU=0.
  - SUB: muxACC=0, opALU=1.
  - Then -> S_FETCH0.
  - Opcode is latched at S_DECODE into an internal op register; IR changes cannot corrupt execute states.
- S_ST0: loadMAR, muxMAR=0 -> S_ST1.
- S_ST1: MemW=1 for exactly one cycle -> S_FETCH0.
- S_JMP: loadPC, muxPC=1 -> S_FETCH0.
- S_MUL: mullACC=1 every cycle in state.
  - mul counter increments each cycle.
  - mullDone sampled 1 -> S_FETCH0; mullACC drops next cycle.
  - Counter reaching MUL_TIMEOUT with mullDone=0 -> err<=1, -> S_HALT.
  - Counter clears on entry.
- S_HALT: terminal, halted=1, no strobes; only rst exits. err stays set until rst.
- instr_count increments by 1 on each transition into S_FETCH0 from an execute state, S_DECODE, or S_MUL success. It does not increment at reset, at HALT, or on timeout. It wraps modulo 2^CNT_W.
- Strobe exclusivity: at most one of loadPC/loadMAR/loadMDR/loadIR/loadACC/MemW/mullACC is high per cycle, except S_FETCH1 (loadMDR+loadPC).
- Instruction latency, counted from S_FETCH0 entry to the next S_FETCH0 entry:
  - NOP, JMPZ not taken: 4 cycles
  - JUMP, JMPZ taken: 5 cycles
  - STORE: 6 cycles
  - LOAD/ADD/SUB: 7 cycles
  - MUL2: 4 + N, where N is the number of cycles in S_MUL (N>=1)

Test Plan:
1. Reset asserted at mid-clock during S_RD1 -> all outputs 0 immediately, next cycle after release shows loadMAR=1, muxMAR=1.
2. opcode=01 (LOAD) -> strobe trace FETCH0..RD2 matches the table; loadACC with muxACC=1 in cycle 7; instr_count 0->1.
3. opcode=06 with zflag=1 -> loadPC, muxPC=1 in cycle 5. With zflag=0 -> next FETCH0 in cycle 5 with no loadPC beyond FETCH1.
4. opcode=07, mullDone raised after 3 S_MUL cycles -> mullACC high exactly 3 cycles, then FETCH0, err=0.
5. opcode=07, mullDone held 0 with MUL_TIMEOUT=16 -> err=1 and halted=1 after 16 S_MUL cycles; outputs stay 0 until rst.
6. Program run of 0x10000 NOPs with CNT_W=16 -> instr_count wraps to 0; opcode=8'hFF behaves as NOP (4 cycles).

Source files
------------

// File: rtl/control_fsm_if.sv
// ---------------------------------------------------------------------------
// control_fsm_if
//
// Bundle of every signal between the instruction-sequencing controller and
// the processor datapath. The controller is the master: it drives the
// load/mux/ALU strobes, the memory write enable and the multiplier request,
// and it publishes its status (halted, err, instr_count). The datapath is
// the slave: it returns the current opcode, the accumulator-zero flag and
// the multiplier completion level.
//
// Parameters
//   CNT_W        width of instr_count, must match the controller's CNT_W
//
// Signals (direction seen from the master / controller)
//   opcode       in   8      IR[7:0] from datapath
//   zflag        in   1      accumulator-zero flag
//   mullDone     in   1      multiplier completion, level
//   muxPC        out  1      1: PC<=IR branch target; 0: PC<=PC+1
//   muxMAR       out  1      1: MAR<=PC; 0: MAR<=IR[15:8]
//   muxACC       out  1      1: ACC<=MDR; 0: ACC<=ALU result
//   loadPC       out  1      PC load strobe
//   loadMAR      out  1      MAR load strobe
//   loadMDR      out  1      MDR<=MemQ strobe
//   loadIR       out  1      IR<=MDR strobe
//   loadACC      out  1      ACC load strobe
//   opALU        out  1      ALU select: 0 ADD, 1 SUB
//   mullACC      out  1      multiplier run request
//   MemW         out  1      memory write enable
//   halted       out  1      high while halted
//   err          out  1      sticky multiplier-timeout flag
//   instr_count  out  CNT_W  retired-instruction count
// ---------------------------------------------------------------------------
interface control_fsm_if #(
  parameter int CNT_W = 16
) ();

  // Datapath -> controller
  logic [7:0]       opcode;
  logic             zflag;
  logic             mullDone;

  // Controller -> datapath strobes
  logic             muxPC;
  logic             muxMAR;
  logic             muxACC;
  logic             loadPC;
  logic             loadMAR;
  logic             loadMDR;
  logic             loadIR;
  logic             loadACC;
  logic             opALU;
  logic             mullACC;
  logic             MemW;

  // Controller status
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zflag, mullDone,
    output muxPC, muxMAR, muxACC,
    output loadPC, loadMAR, loadMDR, loadIR, loadACC,
    output opALU, mullACC, MemW,
    output halted, err, instr_count
  );

  modport slave (
    output opcode, zflag, mullDone,
    input  muxPC, muxMAR, muxACC,
    input  loadPC, loadMAR, loadMDR, loadIR, loadACC,
    input  opALU, mullACC, MemW,
    input  halted, err, instr_count
  );

endinterface : control_fsm_if

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm
//
// Multi-cycle instruction sequencer for the accumulator datapath. Walks each
// instruction through fetch, decode and execute states and drives the
// datapath strobes for every cycle. All strobes are registered Moore
// outputs: they are decoded from the next state and loaded on the same edge
// as the state register, so each strobe is glitch-free and valid for the
// whole cycle the state is occupied.
//
// Instruction latency (S_FETCH0 entry to next S_FETCH0 entry):
//   NOP / undefined / JMPZ not taken : 4
//   JUMP / JMPZ taken                : 5
//   STORE                            : 6
//   LOAD / ADD / SUB                 : 7
//   MUL2                             : 4 + cycles spent in S_MUL
//
// Parameters
//   MUL_TIMEOUT  max S_MUL cycles waited for mullDone before error halt (>=1)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   dp           master side of control_fsm_if (opcode/zflag/mullDone in,
//                strobes, halted, err and instr_count out)
// ---------------------------------------------------------------------------
module control_fsm #(
  parameter int MUL_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master dp
);

  // Wide enough to hold MUL_TIMEOUT itself.
  localparam int MCW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // Opcode map (IR[7:0]); any value not listed executes as NOP.
  // -------------------------------------------------------------------------
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JUMP  = 8'h05;
  localparam logic [7:0] OP_JMPZ  = 8'h06;
  localparam logic [7:0] OP_MUL2  = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'h08;

  typedef enum logic [3:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_ST0,
    S_ST1,
    S_JMP,
    S_MUL,
    S_HALT
  } state_t;

  // One record for every per-cycle datapath control; err lives apart
  // because it is sticky rather than decoded from the state.
  typedef struct packed {
    logic muxPC;
    logic muxMAR;
    logic muxACC;
    logic loadPC;
    logic loadMAR;
    logic loadMDR;
    logic loadIR;
    logic loadACC;
    logic opALU;
    logic mullACC;
    logic MemW;
    logic halted;
  } ctl_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic             r_boot;      // first edge after reset re-enters S_FETCH0
  logic [7:0]       r_op;        // opcode captured when leaving S_DECODE
  logic [MCW-1:0]   r_mul_cnt;   // completed S_MUL cycles of this MUL2
  ctl_t             r_ctl;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  state_t           w_next;
  ctl_t             w_ctl;
  logic             w_retire;    // this edge enters S_FETCH0 after an instruction
  logic             w_timeout;   // this edge gives up on the multiplier

  // -------------------------------------------------------------------------
  // Next-state logic
  //
  // Reset parks the machine in S_FETCH0 with every strobe low. Because the
  // strobes are decoded from the next state, the S_FETCH0 strobes only
  // appear once an edge *enters* S_FETCH0; r_boot makes the first edge after
  // reset do exactly that, without counting it as a retired instruction.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;

    if (r_boot) begin
      w_next = S_FETCH0;
    end else begin
      case (r_state)
        S_FETCH0: w_next = S_FETCH1;
        S_FETCH1: w_next = S_FETCH2;
        S_FETCH2: w_next = S_DECODE;

        // IR is valid here; zflag is only ever looked at in this state.
        S_DECODE: begin
          case (dp.opcode)
            OP_LOAD, OP_ADD, OP_SUB: w_next = S_RD0;
            OP_STORE:                w_next = S_ST0;
            OP_JUMP:                 w_next = S_JMP;
            OP_JMPZ: begin
              if (dp.zflag) begin
                w_next = S_JMP;
              end else begin
                w_next   = S_FETCH0;
                w_retire = 1'b1;
              end
            end
            OP_MUL2:                 w_next = S_MUL;
            OP_HALT:                 w_next = S_HALT;
            default: begin           // OP_NOP and every undefined opcode
              w_next   = S_FETCH0;
              w_retire = 1'b1;
            end
          endcase
        end

        S_RD0: w_next = S_RD1;
        S_RD1: w_next = S_RD2;

        S_RD2, S_ST1, S_JMP: begin
          w_next   = S_FETCH0;
          w_retire = 1'b1;
        end

        S_ST0: w_next = S_ST1;

        // Completion wins over timeout when both land on the last cycle.
        S_MUL: begin
          if (dp.mullDone) begin
            w_next   = S_FETCH0;
            w_retire = 1'b1;
          end else if (r_mul_cnt == MUL_LAST) begin
            w_next    = S_HALT;
            w_timeout = 1'b1;
          end
        end

        S_HALT: w_next = S_HALT;

        // Unused encodings recover to a fresh fetch.
        default: w_next = S_FETCH0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state. Execute strobes in S_RD2 use the
  // opcode captured at decode, so IR changing mid-instruction is harmless.
  // -------------------------------------------------------------------------
  always_comb begin
    w_ctl = '0;
    case (w_next)
      S_FETCH0: begin
        w_ctl.loadMAR = 1'b1;
        w_ctl.muxMAR  = 1'b1;             // MAR <= PC
      end
      S_FETCH1: begin
        w_ctl.loadMDR = 1'b1;
        w_ctl.loadPC  = 1'b1;             // muxPC=0: PC <= PC+1
      end
      S_FETCH2: w_ctl.loadIR  = 1'b1;
      S_RD0:    w_ctl.loadMAR = 1'b1;     // muxMAR=0: MAR <= IR[15:8]
      S_RD1:    w_ctl.loadMDR = 1'b1;
      S_RD2: begin
        w_ctl.loadACC = 1'b1;
        w_ctl.muxACC  = (r_op == OP_LOAD);
        w_ctl.opALU   = (r_op == OP_SUB);
      end
      S_ST0:    w_ctl.loadMAR = 1'b1;
      S_ST1:    w_ctl.MemW    = 1'b1;
      S_JMP: begin
        w_ctl.loadPC  = 1'b1;
        w_ctl.muxPC   = 1'b1;
      end
      S_MUL:    w_ctl.mullACC = 1'b1;
      S_HALT:   w_ctl.halted  = 1'b1;
      default:  w_ctl = '0;               // S_DECODE: no strobes
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH0;
      r_boot    <= 1'b1;
      r_op      <= OP_NOP;
      r_mul_cnt <= '0;
      r_ctl     <= '0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // values from before this edge, independent of statement order.
      r_state <= w_next;
      r_boot  <= 1'b0;
      r_ctl   <= w_ctl;

      if (r_state == S_DECODE) begin
        r_op <= dp.opcode;
      end

      // Held at zero outside S_MUL, which also clears it on every entry.
      if (r_state == S_MUL) begin
        r_mul_cnt <= r_mul_cnt + 1'b1;
      end else begin
        r_mul_cnt <= '0;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end

      // Wraps modulo 2^CNT_W.
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dp.muxPC       = r_ctl.muxPC;
  assign dp.muxMAR      = r_ctl.muxMAR;
  assign dp.muxACC      = r_ctl.muxACC;
  assign dp.loadPC      = r_ctl.loadPC;
  assign dp.loadMAR     = r_ctl.loadMAR;
  assign dp.loadMDR     = r_ctl.loadMDR;
  assign dp.loadIR      = r_ctl.loadIR;
  assign dp.loadACC     = r_ctl.loadACC;
  assign dp.opALU       = r_ctl.opALU;
  assign dp.mullACC     = r_ctl.mullACC;
  assign dp.MemW        = r_ctl.MemW;
  assign dp.halted      = r_ctl.halted;
  assign dp.err         = r_err;
  assign dp.instr_count = r_count;

endmodule : control_fsm

// File: tb/tb_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_fsm
//
// Self-checking bench for control_fsm. A per-cycle table of {opcode, zflag,
// expected strobes, expected instr_count} drives a short program through
// every instruction class; hand-written sequences then cover MUL2
// completion, mid-instruction reset, multiplier timeout and counter wrap.
// A second, narrow-counter instance runs NOPs for the wrap check.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_control_fsm;

  logic clk = 1'b0;
  logic rst;
  logic rst_m;

  always #5 clk = ~clk;

  control_fsm_if #(.CNT_W(16)) bus   ();
  control_fsm_if #(.CNT_W(4))  bus_m ();

  control_fsm #(.MUL_TIMEOUT(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus)
  );

  control_fsm #(.MUL_TIMEOUT(4), .CNT_W(4)) dut_m (
    .clk (clk),
    .rst (rst_m),
    .dp  (bus_m)
  );

  // Strobe bit positions in the compared vector.
  localparam logic [12:0] B_MUXPC  = 13'h1000;
  localparam logic [12:0] B_MUXMAR = 13'h0800;
  localparam logic [12:0] B_MUXACC = 13'h0400;
  localparam logic [12:0] B_LDPC   = 13'h0200;
  localparam logic [12:0] B_LDMAR  = 13'h0100;
  localparam logic [12:0] B_LDMDR  = 13'h0080;
  localparam logic [12:0] B_LDIR   = 13'h0040;
  localparam logic [12:0] B_LDACC  = 13'h0020;
  localparam logic [12:0] B_OPALU  = 13'h0010;
  localparam logic [12:0] B_MUL    = 13'h0008;
  localparam logic [12:0] B_MEMW   = 13'h0004;
  localparam logic [12:0] B_HALT   = 13'h0002;
  localparam logic [12:0] B_ERR    = 13'h0001;

  // Expected output vector for each state.
  localparam logic [12:0] E_NONE = 13'h0000;
  localparam logic [12:0] E_F0   = B_LDMAR | B_MUXMAR;
  localparam logic [12:0] E_F1   = B_LDMDR | B_LDPC;
  localparam logic [12:0] E_F2   = B_LDIR;
  localparam logic [12:0] E_DEC  = E_NONE;
  localparam logic [12:0] E_RD0  = B_LDMAR;
  localparam logic [12:0] E_RD1  = B_LDMDR;
  localparam logic [12:0] E_LD   = B_LDACC | B_MUXACC;
  localparam logic [12:0] E_ADD  = B_LDACC;
  localparam logic [12:0] E_SUB  = B_LDACC | B_OPALU;
  localparam logic [12:0] E_ST0  = B_LDMAR;
  localparam logic [12:0] E_ST1  = B_MEMW;
  localparam logic [12:0] E_JMP  = B_LDPC | B_MUXPC;
  localparam logic [12:0] E_MULS = B_MUL;
  localparam logic [12:0] E_HLT  = B_HALT | B_ERR;

  wire [12:0] w_act = {bus.muxPC, bus.muxMAR, bus.muxACC, bus.loadPC,
                       bus.loadMAR, bus.loadMDR, bus.loadIR, bus.loadACC,
                       bus.opALU, bus.mullACC, bus.MemW, bus.halted, bus.err};

  // One row per clock: outputs expected after the edge, then the inputs
  // driven for the cycle that follows it.
  typedef struct {
    logic [7:0]  op;
    logic        z;
    logic [12:0] exp;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] op, input logic z,
                     input logic [12:0] exp, input int cnt);
    vec_t v;
    v.op  = op;
    v.z   = z;
    v.exp = exp;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // FETCH0..DECODE rows; z_dec is the zflag presented during S_DECODE.
  task automatic add_fetch(input logic [7:0] op, input logic z_pre,
                           input logic z_dec, input int cnt);
    add(op, z_pre, E_F0,  cnt);
    add(op, z_pre, E_F1,  cnt);
    add(op, z_pre, E_F2,  cnt);
    add(op, z_dec, E_DEC, cnt);
  endtask

  task automatic step_chk(input string name, input logic [12:0] exp,
                          input int cnt);
    @(posedge clk);
    #1;
    check({name, ".ctl"}, 32'(w_act), 32'(exp));
    check({name, ".cnt"}, 32'(bus.instr_count), 32'(cnt));
  endtask

  initial begin
    rst          = 1'b0;
    rst_m        = 1'b1;
    bus.opcode   = 8'h00;
    bus.zflag    = 1'b0;
    bus.mullDone = 1'b0;
    bus_m.opcode   = 8'h00;
    bus_m.zflag    = 1'b0;
    bus_m.mullDone = 1'b0;

    // Program: LOAD (IR corrupted during execute), ADD, SUB, STORE, JUMP,
    // JMPZ taken, JMPZ not taken (zflag high outside decode), NOP 0xFF,
    // NOP 0x00, undefined 0x09, then FETCH0 of a MUL2.
    add_fetch(8'h01, 1'b0, 1'b0, 0);
    add(8'h04, 1'b0, E_RD0, 0);
    add(8'h04, 1'b0, E_RD1, 0);
    add(8'h04, 1'b0, E_LD,  0);
    add_fetch(8'h03, 1'b0, 1'b0, 1);
    add(8'h03, 1'b0, E_RD0, 1);
    add(8'h03, 1'b0, E_RD1, 1);
    add(8'h03, 1'b0, E_ADD, 1);
    add_fetch(8'h04, 1'b0, 1'b0, 2);
    add(8'h04, 1'b0, E_RD0, 2);
    add(8'h04, 1'b0, E_RD1, 2);
    add(8'h04, 1'b0, E_SUB, 2);
    add_fetch(8'h02, 1'b0, 1'b0, 3);
    add(8'h02, 1'b0, E_ST0, 3);
    add(8'h02, 1'b0, E_ST1, 3);
    add_fetch(8'h05, 1'b0, 1'b0, 4);
    add(8'h05, 1'b0, E_JMP, 4);
    add_fetch(8'h06, 1'b0, 1'b1, 5);
    add(8'h06, 1'b0, E_JMP, 5);
    add_fetch(8'h06, 1'b1, 1'b0, 6);
    add_fetch(8'hFF, 1'b0, 1'b0, 7);
    add_fetch(8'h00, 1'b0, 1'b0, 8);
    add_fetch(8'h09, 1'b0, 1'b0, 9);
    add(8'h07, 1'b0, E_F0, 10);

    // Asynchronous reset with no clock edge involved, then across edges.
    #1 rst = 1'b1;
    #1;
    check("reset_async.ctl", 32'(w_act), 32'(E_NONE));
    check("reset_async.cnt", 32'(bus.instr_count), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_held.ctl", 32'(w_act), 32'(E_NONE));
    rst = 1'b0;

    // Table-driven program.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.ctl", i), 32'(w_act), 32'(vecs[i].exp));
      check($sformatf("vec%0d.cnt", i), 32'(bus.instr_count), 32'(vecs[i].cnt));
      bus.opcode = vecs[i].op;
      bus.zflag  = vecs[i].z;
    end

    // MUL2 with mullDone seen on the third S_MUL cycle: 4+3 cycles total.
    step_chk("mul_f1",  E_F1,  10);
    step_chk("mul_f2",  E_F2,  10);
    step_chk("mul_dec", E_DEC, 10);
    for (int k = 1; k <= 3; k++) begin
      step_chk($sformatf("mul_run%0d", k), E_MULS, 10);
      if (k == 3) bus.mullDone = 1'b1;
    end
    step_chk("mul_done", E_F0, 11);
    bus.mullDone = 1'b0;

    // LOAD abandoned by a reset asserted mid-cycle in S_RD1.
    bus.opcode = 8'h01;
    step_chk("rr_f1",  E_F1,  11);
    step_chk("rr_f2",  E_F2,  11);
    step_chk("rr_dec", E_DEC, 11);
    step_chk("rr_rd0", E_RD0, 11);
    step_chk("rr_rd1", E_RD1, 11);
    #4 rst = 1'b1;
    #1;
    check("rr_reset.ctl", 32'(w_act), 32'(E_NONE));
    check("rr_reset.cnt", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step_chk("rr_release", E_F0, 0);

    // MUL2 with mullDone never arriving: 16 S_MUL cycles, then error halt.
    bus.opcode = 8'h07;
    step_chk("to_f1",  E_F1,  0);
    step_chk("to_f2",  E_F2,  0);
    step_chk("to_dec", E_DEC, 0);
    for (int k = 1; k <= 16; k++) begin
      step_chk($sformatf("to_run%0d", k), E_MULS, 0);
    end
    step_chk("to_halt", E_HLT, 0);
    bus.opcode   = 8'h00;
    bus.mullDone = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_chk($sformatf("to_hold%0d", k), E_HLT, 0);
    end
    bus.mullDone = 1'b0;
    rst = 1'b1;
    #1;
    check("to_reset.ctl", 32'(w_act), 32'(E_NONE));
    @(negedge clk);
    rst = 1'b0;
    step_chk("to_restart", E_F0, 0);

    // Counter wrap on the 4-bit instance running back-to-back NOPs:
    // count k appears on edge 4k+1 after release, so 16 NOPs wrap to 0.
    @(negedge clk);
    rst_m = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      @(posedge clk);
      #1;
      if (e == 1)  check("wrap_boot_ldmar", 32'(bus_m.loadMAR), 32'd1);
      if (e == 5)  check("wrap_first",      32'(bus_m.instr_count), 32'd1);
      if (e == 64) check("wrap_before",     32'(bus_m.instr_count), 32'd15);
      if (e == 65) begin
        check("wrap_zero",  32'(bus_m.instr_count), 32'd0);
        check("wrap_ldmar", 32'(bus_m.loadMAR), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_control_fsm
